// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage between execute and writeback.
//   Holds one instruction, waits for the data_ok of its load/store, aligns and
//   extends load data, parks a response that arrives while writeback stalls,
//   discards responses belonging to flushed requests, and drives forwarding.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   ws_allowin            writeback can accept this cycle
//   ms_allowin            this stage can accept this cycle
//   es_to_ms_valid/bus    instruction bus from execute
//   es_mem_inflight       execute holds an accepted memory request
//   ms_to_ws_valid/bus    instruction bus to writeback
//   data_sram_data_ok     in-order response strobe from data memory
//   data_sram_rdata       response read data (word-lane aligned)
//   ms_fwd_bus            {load_pending, wr_valid, dest, result}
//   ms_ex                 valid instruction here carries an exception
//   flush                 exception/eret flush from writeback
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 131,
    parameter int MS_TO_WS_BUS_WD = 126,
    parameter int MS_FWD_BUS_WD   = 39
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_mem_inflight,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    output logic                       ms_ex,
    input  logic                       flush
);

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
    logic                       r_data_buf_valid;
    logic [31:0]                r_data_buf;
    logic [1:0]                 r_cancel_cnt;

    // Field decode of the registered execute bus
    logic        w_tlbwi, w_tlbr, w_store_op, w_bd, w_ex, w_res_from_mem, w_gr_we;
    logic [31:0] w_badvaddr, w_res, w_pc;
    logic [10:0] w_c0_bus;
    logic [4:0]  w_excode, w_dest;
    logic [6:0]  w_ld_inst;
    logic        w_lw, w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr;

    assign w_tlbwi        = r_es_bus[130];
    assign w_tlbr         = r_es_bus[129];
    assign w_store_op     = r_es_bus[128];
    assign w_badvaddr     = r_es_bus[127:96];
    assign w_c0_bus       = r_es_bus[95:85];
    assign w_bd           = r_es_bus[84];
    assign w_ex           = r_es_bus[83];
    assign w_excode       = r_es_bus[82:78];
    assign w_ld_inst      = r_es_bus[77:71];
    assign w_res_from_mem = r_es_bus[70];
    assign w_gr_we        = r_es_bus[69];
    assign w_dest         = r_es_bus[68:64];
    assign w_res          = r_es_bus[63:32];
    assign w_pc           = r_es_bus[31:0];

    assign {w_lw, w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr} = w_ld_inst;

    // Handshake
    logic w_mem_op, w_got_data, w_ready_go;

    assign w_mem_op   = w_res_from_mem | w_store_op;
    assign w_got_data = data_sram_data_ok && (r_cancel_cnt == 2'd0) && r_ms_valid && w_mem_op && !w_ex;
    assign w_ready_go = !w_mem_op | w_ex | w_got_data | r_data_buf_valid;

    assign ms_allowin     = !r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go & !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (flush) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_es_bus <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            r_es_bus <= es_to_ms_bus;
        end
    end

    // Response parking while writeback stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_buf_valid <= 1'b0;
            r_data_buf       <= '0;
        end else if (flush || (ms_to_ws_valid && ws_allowin)) begin
            r_data_buf_valid <= 1'b0;
        end else if (w_got_data && !ws_allowin) begin
            r_data_buf_valid <= 1'b1;
            r_data_buf       <= data_sram_rdata;
        end
    end

    // Stale-response counter: a flush orphans the request of the instruction
    // held here (if its data has not come back) plus any request still held in
    // execute. Each orphaned response is swallowed as it arrives in order.
    logic       w_req_pending;
    logic       w_cancel_hit;
    logic [1:0] w_cancel_inc;
    logic [1:0] w_cancel_nxt;

    assign w_req_pending = r_ms_valid & w_mem_op & !w_ex & !w_got_data & !r_data_buf_valid;
    assign w_cancel_hit  = data_sram_data_ok & (r_cancel_cnt != 2'd0);
    assign w_cancel_inc  = {1'b0, w_req_pending} + {1'b0, es_mem_inflight};

    always_comb begin
        w_cancel_nxt = r_cancel_cnt;
        if (flush) begin
            w_cancel_nxt = r_cancel_cnt + w_cancel_inc - {1'b0, w_cancel_hit};
        end else if (w_cancel_hit) begin
            w_cancel_nxt = r_cancel_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cancel_cnt <= 2'd0;
        end else begin
            r_cancel_cnt <= w_cancel_nxt;
        end
    end

    // Load alignment / extension
    logic [31:0] w_load_data;
    logic [1:0]  w_pos;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_result;
    logic [3:0]  w_load_wstrb;

    assign w_load_data = r_data_buf_valid ? r_data_buf : data_sram_rdata;
    assign w_pos       = w_res[1:0];
    assign w_half      = w_pos[1] ? w_load_data[31:16] : w_load_data[15:0];

    always_comb begin
        case (w_pos)
            2'd0:    w_byte = w_load_data[7:0];
            2'd1:    w_byte = w_load_data[15:8];
            2'd2:    w_byte = w_load_data[23:16];
            default: w_byte = w_load_data[31:24];
        endcase
    end

    always_comb begin
        w_load_result = w_load_data;
        w_load_wstrb  = 4'b1111;
        if (w_lb) begin
            w_load_result = {{24{w_byte[7]}}, w_byte};
        end else if (w_lbu) begin
            w_load_result = {24'h0, w_byte};
        end else if (w_lh) begin
            w_load_result = {{16{w_half[15]}}, w_half};
        end else if (w_lhu) begin
            w_load_result = {16'h0, w_half};
        end else if (w_lwl) begin
            case (w_pos)
                2'd0:    begin w_load_result = {w_load_data[7:0], 24'h0};  w_load_wstrb = 4'b1000; end
                2'd1:    begin w_load_result = {w_load_data[15:0], 16'h0}; w_load_wstrb = 4'b1100; end
                2'd2:    begin w_load_result = {w_load_data[23:0], 8'h0};  w_load_wstrb = 4'b1110; end
                default: begin w_load_result = w_load_data;                w_load_wstrb = 4'b1111; end
            endcase
        end else if (w_lwr) begin
            case (w_pos)
                2'd0:    begin w_load_result = w_load_data;                 w_load_wstrb = 4'b1111; end
                2'd1:    begin w_load_result = {8'h0, w_load_data[31:8]};   w_load_wstrb = 4'b0111; end
                2'd2:    begin w_load_result = {16'h0, w_load_data[31:16]}; w_load_wstrb = 4'b0011; end
                default: begin w_load_result = {24'h0, w_load_data[31:24]}; w_load_wstrb = 4'b0001; end
            endcase
        end else begin
            w_load_result = w_load_data;  // lw
        end
    end

    // Outgoing result: an excepting instruction carries res unchanged and writes nothing
    logic [31:0] w_result;
    logic [3:0]  w_rf_wstrb;
    logic        w_gr_we_out;

    assign w_result    = (w_res_from_mem & !w_ex) ? w_load_result : w_res;
    assign w_rf_wstrb  = w_ex ? 4'b0000 : (w_res_from_mem ? w_load_wstrb : 4'b1111);
    assign w_gr_we_out = w_gr_we & !w_ex;

    assign ms_to_ws_bus = {w_tlbwi, w_tlbr, w_badvaddr, w_c0_bus, w_bd, w_ex, w_excode,
                           w_gr_we_out, w_rf_wstrb, w_dest, w_result, w_pc};

    logic w_load_pending, w_wr_valid;

    assign w_load_pending = r_ms_valid & w_res_from_mem & !w_ex & !w_got_data & !r_data_buf_valid;
    assign w_wr_valid     = r_ms_valid & w_gr_we & !w_ex;
    assign ms_fwd_bus     = {w_load_pending, w_wr_valid, w_dest, w_result};

    assign ms_ex = r_ms_valid & w_ex;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Drives mem_stage as execute stage plus data memory. Each accepted
//   instruction's expected writeback bus is queued; a monitor pops and
//   compares whenever the stage hands an instruction to writeback.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    localparam int ES_WD  = 131;
    localparam int WS_WD  = 126;
    localparam int FWD_WD = 39;

    localparam int K_LW = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4, K_LWL = 5, K_LWR = 6;
    localparam int K_SW = 7, K_ALU = 8, K_EXLD = 9;

    logic              clk, reset, ws_allowin, ms_allowin, es_to_ms_valid, es_mem_inflight;
    logic              ms_to_ws_valid, data_sram_data_ok, ms_ex, flush;
    logic [ES_WD-1:0]  es_to_ms_bus;
    logic [WS_WD-1:0]  ms_to_ws_bus;
    logic [31:0]       data_sram_rdata;
    logic [FWD_WD-1:0] ms_fwd_bus;

    mem_stage #(
        .ES_TO_MS_BUS_WD(ES_WD),
        .MS_TO_WS_BUS_WD(WS_WD),
        .MS_FWD_BUS_WD  (FWD_WD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ws_allowin       (ws_allowin),
        .ms_allowin       (ms_allowin),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .es_mem_inflight  (es_mem_inflight),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_to_ws_bus     (ms_to_ws_bus),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata),
        .ms_fwd_bus       (ms_fwd_bus),
        .ms_ex            (ms_ex),
        .flush            (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        stale;
        logic [31:0] rdata;
    } resp_t;

    logic [WS_WD-1:0] exp_q[$];   // expected writeback buses, in order
    resp_t            resp_q[$];  // memory responses still owed, in order

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference load semantics expressed per register byte
    function automatic void ref_load(input int kind, input logic [1:0] pos_l, input logic [31:0] rd,
                                     output logic [31:0] result, output logic [3:0] wstrb);
        logic [7:0] b[4];
        logic [7:0] o[4];
        int p, h;
        p = int'(pos_l);
        h = (p / 2) * 2;
        for (int i = 0; i < 4; i++) begin
            b[i] = rd[8*i +: 8];
            o[i] = 8'h00;
        end
        result = rd;
        wstrb  = 4'b1111;
        case (kind)
            K_LB:  result = {{24{b[p][7]}}, b[p]};
            K_LBU: result = {24'h0, b[p]};
            K_LH:  result = {{16{b[h+1][7]}}, b[h+1], b[h]};
            K_LHU: result = {16'h0, b[h+1], b[h]};
            K_LWL: begin
                wstrb = 4'b0000;
                for (int k = 0; k <= p; k++) begin
                    o[3-p+k]     = b[k];
                    wstrb[3-p+k] = 1'b1;
                end
                result = {o[3], o[2], o[1], o[0]};
            end
            K_LWR: begin
                wstrb = 4'b0000;
                for (int k = 0; k <= 3 - p; k++) begin
                    o[k]     = b[p+k];
                    wstrb[k] = 1'b1;
                end
                result = {o[3], o[2], o[1], o[0]};
            end
            default: ;
        endcase
    endfunction

    function automatic void build(input int kind, input logic [31:0] res, input logic [31:0] rd,
                                  output logic [ES_WD-1:0] eb, output logic [WS_WD-1:0] wb,
                                  output bit mem);
        logic        tlbwi, tlbr, bd, ex, store, rfm, gr_we, gr_out;
        logic [31:0] badv, pc, result;
        logic [10:0] c0;
        logic [4:0]  excode, dest;
        logic [6:0]  ld;
        logic [3:0]  wstrb;
        tlbwi  = 1'($urandom);
        tlbr   = 1'($urandom);
        bd     = 1'($urandom);
        badv   = $urandom;
        pc     = $urandom;
        c0     = 11'($urandom);
        excode = 5'($urandom);
        dest   = 5'($urandom);
        ex     = (kind == K_EXLD);
        store  = (kind == K_SW);
        rfm    = (kind <= K_LWR) || ex;
        ld     = 7'b0;
        if (kind <= K_LWR) ld = 7'b1000000 >> kind;
        else if (ex)       ld = 7'b1000000;
        gr_we  = store ? 1'b0 : 1'($urandom);
        mem    = (kind <= K_SW);
        result = res;
        wstrb  = 4'b1111;
        if (kind <= K_LWR) ref_load(kind, res[1:0], rd, result, wstrb);
        if (ex) wstrb = 4'b0000;
        gr_out = gr_we & ~ex;
        eb = {tlbwi, tlbr, store, badv, c0, bd, ex, excode, ld, rfm, gr_we, dest, res, pc};
        wb = {tlbwi, tlbr, badv, c0, bd, ex, excode, gr_out, wstrb, dest, result, pc};
    endfunction

    // Monitor: every transfer to writeback must match the oldest expectation
    initial begin
        logic [WS_WD-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && ms_to_ws_valid && ws_allowin) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 128'(ms_to_ws_bus), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("ws_bus", 128'(ms_to_ws_bus), 128'(e));
                    check("fwd_bus", 128'(ms_fwd_bus), 128'({1'b0, e[73], e[68:64], e[63:32]}));
                    check("ms_ex", 128'(ms_ex), 128'(e[79]));
                end
            end
        end
    end

    // One random cycle, entered and left at a falling edge
    task automatic drive_cycle(input bit allow_issue, input bit allow_flush);
        logic [ES_WD-1:0] eb;
        logic [WS_WD-1:0] wb;
        logic [31:0]      rd;
        resp_t            r;
        bit               mem, any_stale;
        int               kind;
        any_stale = 1'b0;
        foreach (resp_q[i]) if (resp_q[i].stale) any_stale = 1'b1;
        ws_allowin = ($urandom_range(0, 9) < 7);
        if (resp_q.size() != 0 && $urandom_range(0, 1) == 1) begin
            r = resp_q.pop_front();
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = r.rdata;
        end else begin
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
        end
        flush           = 1'b0;
        es_mem_inflight = 1'b0;
        es_to_ms_valid  = 1'b0;
        if (allow_flush && !any_stale && $urandom_range(0, 19) == 0) begin
            flush = 1'b1;
            exp_q.delete();
            foreach (resp_q[i]) resp_q[i].stale = 1'b1;
            if (resp_q.size() <= 1 && $urandom_range(0, 1) == 1) begin
                es_mem_inflight = 1'b1;
                r.stale = 1'b1;
                r.rdata = $urandom;
                resp_q.push_back(r);
            end
        end else if (allow_issue && $urandom_range(0, 9) < 6) begin
            kind = (resp_q.size() > 1) ? $urandom_range(K_ALU, K_EXLD) : $urandom_range(K_LW, K_EXLD);
            rd   = $urandom;
            build(kind, $urandom, rd, eb, wb, mem);
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = eb;
            #1;
            if (ms_allowin) begin
                exp_q.push_back(wb);
                if (mem) begin
                    r.stale = 1'b0;
                    r.rdata = rd;
                    resp_q.push_back(r);
                end
            end
        end
        @(negedge clk);
    endtask

    // Single load with data_ok one cycle after entry; writeback stalls for 'stall' cycles
    task automatic run_load(input string nm, input int kind, input logic [31:0] res,
                            input logic [31:0] rd, input int stall,
                            input logic [31:0] exp_res, input logic [3:0] exp_wstrb);
        logic [ES_WD-1:0] eb;
        logic [WS_WD-1:0] wb;
        bit               mem;
        build(kind, res, rd, eb, wb, mem);
        flush = 1'b0; es_mem_inflight = 1'b0; data_sram_data_ok = 1'b0; ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = eb;
        #1;
        check({nm, "_allowin"}, 128'(ms_allowin), 128'(1));
        exp_q.push_back(wb);
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        ws_allowin        = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
            ws_allowin        = (i == stall - 1);
        end
        #1;
        check({nm, "_valid"}, 128'(ms_to_ws_valid), 128'(1));
        check({nm, "_result"}, 128'(ms_to_ws_bus[63:32]), 128'(exp_res));
        check({nm, "_wstrb"}, 128'(ms_to_ws_bus[72:69]), 128'(exp_wstrb));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || resp_q.size() != 0) && k < 400) begin
            drive_cycle(1'b0, 1'b0);
            k++;
        end
        check("drain", 128'(exp_q.size() + resp_q.size()), 128'(0));
        data_sram_data_ok = 1'b0;
        ws_allowin        = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [ES_WD-1:0] eb;
        logic [WS_WD-1:0] wb;
        bit               mem;

        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        es_mem_inflight = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ws_valid", 128'(ms_to_ws_valid), 128'(0));
        check("rst_allowin", 128'(ms_allowin), 128'(1));
        check("rst_ms_ex", 128'(ms_ex), 128'(0));
        check("rst_fwd_flags", 128'(ms_fwd_bus[38:37]), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        run_load("lb_pos3", K_LB, 32'h0000_1003, 32'h80AB_CD12, 0, 32'hFFFF_FF80, 4'b1111);
        run_load("lwl_pos1", K_LWL, 32'h0000_2001, 32'h1122_3344, 0, 32'h3344_0000, 4'b1100);
        run_load("lwr_pos2", K_LWR, 32'h0000_2002, 32'h1122_3344, 0, 32'h0000_1122, 4'b0011);
        run_load("lw_stall", K_LW, 32'h0000_3000, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 4'b1111);

        repeat (3000) drive_cycle(1'b1, 1'b1);
        drain();

        // Orphan two responses, start a new load, then reset in the middle of its wait
        build(K_LW, 32'h0000_4000, 32'h0, eb, wb, mem);
        es_to_ms_valid = 1'b1; es_to_ms_bus = eb; ws_allowin = 1'b1;
        #1;
        check("cx_allowin", 128'(ms_allowin), 128'(1));
        exp_q.push_back(wb);
        @(negedge clk);
        es_to_ms_valid = 1'b0; flush = 1'b1; es_mem_inflight = 1'b1;
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0; es_mem_inflight = 1'b0;
        build(K_LW, 32'h0000_4004, 32'h0, eb, wb, mem);
        es_to_ms_valid = 1'b1; es_to_ms_bus = eb;
        #1;
        check("cx_allowin2", 128'(ms_allowin), 128'(1));
        exp_q.push_back(wb);
        @(negedge clk);
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = $urandom;
        #1;
        check("stale_dropped", 128'(ms_to_ws_valid), 128'(0));
        check("load_pending", 128'(ms_fwd_bus[38]), 128'(1));
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        resp_q.delete();
        check("mid_rst_ws_valid", 128'(ms_to_ws_valid), 128'(0));
        check("mid_rst_allowin", 128'(ms_allowin), 128'(1));
        check("mid_rst_ms_ex", 128'(ms_ex), 128'(0));
        check("mid_rst_fwd_flags", 128'(ms_fwd_bus[38:37]), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_load("post_rst_lbu", K_LBU, 32'h0000_5002, 32'h12C3_4567, 0, 32'h0000_00C3, 4'b1111);
        repeat (2) @(negedge clk);
        check("final_queue", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
